// File: rtl/filter_pkg.sv
// Shared definitions for the 3-phase polyphase IIR filter: controller state
// encoding and the default lane count and latencies used by the filter top.
package filter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  localparam int DEF_NUM_PHASES   = 3;
  localparam int DEF_FLUSH_CYCLES = 6;
  localparam int DEF_FILL_LATENCY = 12;

  // Bits needed for a counter that runs 0..max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/filter_phase_cnt.sv
// Modulo-N phase counter with synchronous clear and count enable; o_wrap
// marks the last phase. Shared by the sequencing controller and the output mux.
module filter_phase_cnt
  import filter_pkg::*;
#(
  parameter int N = DEF_NUM_PHASES,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_phase,
  output logic         o_wrap
);

  logic [W-1:0] r_phase;

  assign o_wrap  = (r_phase == W'(N - 1));
  assign o_phase = r_phase;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= o_wrap ? '0 : r_phase + W'(1);
    end
  end

endmodule

// File: rtl/filter_phase_ctrl.sv
// Sequencing controller for the polyphase IIR datapath: flush, pipeline fill,
// then run, with lane strobes, divided-rate enable and mux select decoded from phase.
module filter_phase_ctrl
  import filter_pkg::*;
#(
  parameter int NUM_PHASES     = DEF_NUM_PHASES,
  parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  parameter int FILL_LATENCY   = DEF_FILL_LATENCY,
  parameter int OUT_SEL_OFFSET = 0,
  parameter int PH_W           = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  resync,
  output logic [PH_W-1:0]       phase,
  output logic                  ce_div,
  output logic [NUM_PHASES-1:0] lane_load,
  output logic [PH_W-1:0]       out_sel,
  output logic                  flush,
  output logic                  out_valid,
  output logic                  busy,
  output logic [1:0]            state_o
);

  localparam int CNT_W = cnt_width(FLUSH_CYCLES, FILL_LATENCY);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'((FILL_LATENCY == 0) ? 0 : FILL_LATENCY - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_restart;
  logic             w_ph_clr;
  logic             w_wrap;
  logic [PH_W-1:0]  w_phase;
  logic [PH_W:0]    w_sel_sum;

  // en=0 outranks resync; a resync while active restarts the flush from scratch.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (resync) begin
          w_restart = 1'b1;
        end else if (r_cnt == FLUSH_LAST) begin
          w_state_nxt = (FILL_LATENCY == 0) ? S_RUN : S_FILL;
        end
      end
      S_FILL: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (resync) begin
          w_state_nxt = S_FLUSH;
          w_restart   = 1'b1;
        end else if (r_cnt == FILL_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (resync) begin
          w_state_nxt = S_FLUSH;
          w_restart   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((w_state_nxt != r_state) || w_restart) begin
      r_cnt <= '0;
    end else if ((r_state == S_FLUSH) || (r_state == S_FILL)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // FLUSH_CYCLES is a multiple of NUM_PHASES, so phase wraps to 0 on FILL entry unaided.
  assign w_ph_clr = (w_state_nxt == S_IDLE) || w_restart;

  filter_phase_cnt #(
    .N (NUM_PHASES),
    .W (PH_W)
  ) u_phase_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_ph_clr),
    .i_en    (r_state != S_IDLE),
    .o_phase (w_phase),
    .o_wrap  (w_wrap)
  );

  assign w_sel_sum = {1'b0, w_phase} + (PH_W + 1)'(OUT_SEL_OFFSET);

  assign phase     = w_phase;
  assign ce_div    = w_wrap && (r_state != S_IDLE);
  assign lane_load = ((r_state == S_FILL) || (r_state == S_RUN)) ?
                     (NUM_PHASES'(1) << w_phase) : '0;
  assign out_sel   = (w_sel_sum >= (PH_W + 1)'(NUM_PHASES)) ?
                     PH_W'(w_sel_sum - (PH_W + 1)'(NUM_PHASES)) : w_sel_sum[PH_W-1:0];
  assign flush     = (r_state == S_FLUSH);
  assign out_valid = (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign state_o   = r_state;

endmodule

// File: tb/tb_filter_phase_ctrl.sv
// Bench for filter_phase_ctrl: directed sequences plus random en/resync/reset
// traffic, checked every cycle against a time-since-flush reference model.
module tb_filter_phase_ctrl;

  localparam int N  = 3;
  localparam int FC = 6;
  localparam int FL = 12;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic resync = 1'b0;

  logic [PW-1:0] a_phase, b_phase;
  logic          a_ce_div, b_ce_div;
  logic [N-1:0]  a_lane_load, b_lane_load;
  logic [PW-1:0] a_out_sel, b_out_sel;
  logic          a_flush, b_flush;
  logic          a_out_valid, b_out_valid;
  logic          a_busy, b_busy;
  logic [1:0]    a_state_o, b_state_o;

  filter_phase_ctrl #(
    .NUM_PHASES(N), .FLUSH_CYCLES(FC), .FILL_LATENCY(FL), .OUT_SEL_OFFSET(0)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .resync(resync),
    .phase(a_phase), .ce_div(a_ce_div), .lane_load(a_lane_load), .out_sel(a_out_sel),
    .flush(a_flush), .out_valid(a_out_valid), .busy(a_busy), .state_o(a_state_o)
  );

  filter_phase_ctrl #(
    .NUM_PHASES(N), .FLUSH_CYCLES(FC), .FILL_LATENCY(FL), .OUT_SEL_OFFSET(2)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en), .resync(resync),
    .phase(b_phase), .ce_div(b_ce_div), .lane_load(b_lane_load), .out_sel(b_out_sel),
    .flush(b_flush), .out_valid(b_out_valid), .busy(b_busy), .state_o(b_state_o)
  );

  always #5 clk = ~clk;

  // Model: whether a sequence is active, and cycles elapsed since its flush began.
  bit m_act;
  int m_t;
  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int es, ep, ell;
    es  = !m_act ? 0 : (m_t < FC) ? 1 : (m_t < FC + FL) ? 2 : 3;
    ep  = m_act ? (m_t % N) : 0;
    ell = (es >= 2) ? (1 << ep) : 0;
    check("state",     32'(a_state_o),   32'(es));
    check("phase",     32'(a_phase),     32'(ep));
    check("ce_div",    32'(a_ce_div),    32'(m_act && ep == N - 1));
    check("lane_load", 32'(a_lane_load), 32'(ell));
    check("out_sel",   32'(a_out_sel),   32'(ep));
    check("flush",     32'(a_flush),     32'(es == 1));
    check("out_valid", 32'(a_out_valid), 32'(es == 3));
    check("busy",      32'(a_busy),      32'(m_act));
    check("b_out_sel", 32'(b_out_sel),   32'((ep + 2) % N));
    check("b_state",   32'(b_state_o),   32'(es));
    check("b_lane",    32'(b_lane_load), 32'(ell));
  endtask

  task automatic step(input logic r, input logic e, input logic s);
    reset  = r;
    en     = e;
    resync = s;
    @(posedge clk);
    if (r || !e) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (!m_act) begin
      m_act = 1'b1;
      m_t   = 0;
    end else if (s) begin
      m_t = 0;
    end else begin
      m_t++;
    end
    #1;
    compare_all();
  endtask

  initial begin
    int lat;
    m_act  = 1'b0;
    m_t    = 0;
    checks = 0;
    errors = 0;

    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    check("idle_phase", 32'(a_phase), 32'd0);
    check("idle_out_sel_off2", 32'(b_out_sel), 32'd2);

    // en rises: measure flush-to-valid latency with a bounded wait
    step(0, 1, 0);
    check("flush_first", 32'(a_flush), 32'd1);
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      step(0, 1, 0);
      lat++;
    end
    check("fill_latency", 32'(lat), 32'(FC + FL));

    for (int i = 0; i < 10; i++) step(0, 1, 0);
    step(0, 1, 1);
    check("resync_phase", 32'(a_phase), 32'd0);
    check("resync_flush", 32'(a_flush), 32'd1);
    check("resync_valid", 32'(a_out_valid), 32'd0);
    for (int i = 0; i < 25; i++) step(0, 1, 0);
    check("rerun_valid", 32'(a_out_valid), 32'd1);

    // en drop in RUN, immediate re-enable
    step(0, 0, 0);
    check("drop_lane", 32'(a_lane_load), 32'd0);
    step(0, 1, 0);
    check("reen_flush", 32'(a_flush), 32'd1);

    // resync inside FLUSH restarts it
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 25; i++) step(0, 1, 0);

    // resync together with en=0: IDLE wins
    step(0, 0, 1);
    check("simul_state", 32'(a_state_o), 32'd0);
    step(0, 0, 0);
    check("simul_no_flush", 32'(a_flush), 32'd0);

    // reset mid-FILL
    step(0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    step(1, 1, 0);
    check("rst_fill_state", 32'(a_state_o), 32'd0);
    check("rst_fill_sel", 32'(b_out_sel), 32'd2);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 97),
           ($urandom_range(0, 99) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
